hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Decode-stage hazard controller for the 5-stage MIPS pipeline with branch compare in ID.
//  Detects load-use, ALU->branch and load->branch hazards, and counts the stall cycles each one needs.
//  Drives PC / IF-ID write enables, the ID-EX bubble and the IF-ID flush.
//  Handles multi-cycle data-memory freezes and flushes only on taken branches.
//  Sits between the ID decoder / ID comparator and the pipeline-register enables.
// PARAMETERS
//  AW        5   register-address width
//  CNT_W     2   stall-counter width; must hold 2
//  PERF_W    16  width of saturating stall-cycle performance counter
//  ZERO_REG  1   1: register 0 never creates a hazard
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous reset, active low
//  id_rs, id_rt    in   AW      source registers of the instruction in ID
//  id_use_rs/rt    in   1       instruction actually reads rs / rt
//  id_is_branch    in   1       beq/bne in ID
//  id_br_taken     in   1       ID comparator result; valid only when stall_o=0
//  ex_rd           in   AW      destination register in EX
//  ex_reg_write    in   1       EX instruction writes a register
//  ex_mem_read     in   1       EX instruction is a load
//  mem_rd          in   AW      destination register in MEM
//  mem_mem_read    in   1       MEM instruction is a load
//  mem_busy        in   1       data memory not done; whole pipe must hold
//  pc_we           out  1       PC write enable
//  ifid_we         out  1       IF/ID write enable
//  idex_bubble     out  1       force control signals in ID/EX to zero
//  ifid_flush      out  1       squash the IF/ID entry (taken branch)
//  pipe_freeze     out  1       hold every pipeline register (mem_busy)
//  stall_o         out  1       ID is stalled this cycle
//  stall_cycles    out  PERF_W  saturating count of stall and freeze cycles
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, stall_cycles=0.
//   Reset output values: pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush=0, pipe_freeze=0, stall_o=0.
//  Match(x) = (id_use_rs & x==id_rs) | (id_use_rt & x==id_rt). Forced false if ZERO_REG and x==0.
//  Required stalls, req (first matching rule wins):
//   1) ex_mem_read & Match(ex_rd) & id_is_branch  -> 2
//   2) ex_mem_read & Match(ex_rd)                 -> 1
//   3) ex_reg_write & Match(ex_rd) & id_is_branch -> 1
//   4) mem_mem_read & Match(mem_rd) & id_is_branch -> 1
//   5) none                                       -> 0
//  FSM states: IDLE, STALL, FREEZE. Registered state and cnt.
//   IDLE:   mem_busy -> FREEZE. Else if req>0: assert stall combinationally this cycle,
//           load cnt=req-1, go to STALL when req-1>0, otherwise stay in IDLE.
//   STALL:  mem_busy -> FREEZE (cnt held, return to STALL).
//           Else stall; cnt-- ; when cnt reaches 0 go to IDLE. Hazards not re-evaluated in STALL.
//   FREEZE: pipe_freeze=1, pc_we=ifid_we=0, idex_bubble=0.
//           Leave on first cycle with mem_busy=0, back to the saved state (IDLE or STALL); cnt unchanged.
//  Stall cycle outputs: pc_we=0, ifid_we=0, idex_bubble=1, stall_o=1, ifid_flush=0.
//  ifid_flush = id_is_branch & id_br_taken & !stall_o & !pipe_freeze (1-cycle, combinational).
//   Not-taken branches never flush.
//  stall_cycles increments on every stall_o or pipe_freeze cycle and saturates at all-ones.
//  Zero latency: all enables are valid in the same cycle as their inputs.
//  mem_busy asserted in the same cycle as a new hazard: FREEZE wins, and the hazard is re-evaluated on exit.
//  Reset during STALL/FREEZE returns to IDLE immediately; the pending stall is dropped.
// STRUCTURE
//  Shared header hazard_defs.vh: state encodings, plus stall constants LU_STALL=1, LU_BR_STALL=2, ALU_BR_STALL=1.
//  One sub-module, hazard_match (AW-parametrised): evaluates Match(x); instantiated once each for EX and MEM.
//  FSM, counter and perf counter all live in this module.
// TESTING
//  1 lw $2 in EX; add reads $2 in ID -> 1 stall cycle: pc_we=0, idex_bubble=1; next cycle pc_we=1.
//  2 lw $3 in EX; beq reads $3 -> stall_o high 2 consecutive cycles; stall_cycles +2.
//  3 add $4 in EX; bne reads $4 -> 1 stall cycle; branch taken next cycle -> ifid_flush=1 for 1 cycle.
//  4 beq not taken, no hazard -> ifid_flush=0, stall_o=0. Rule 2 with ex_rd=0 -> no stall.
//  5 Rule-1 stall with mem_busy raised for 3 cycles after the first stall cycle:
//    -> pipe_freeze=1 for 3 cycles, then exactly 1 more stall cycle; stall_cycles +5.
//  6 rst_n dropped mid-STALL -> outputs return to reset values asynchronously; stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared definitions for the decode-stage hazard controller:
//     - FSM state encoding
//     - stall-length constants for each hazard class
//     - hz_req(): picks how many stall cycles the ID instruction needs
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } hz_state_e;

    typedef logic [1:0] stall_req_t;

    // Load result needed by the ID comparator: the load must reach WB first.
    localparam stall_req_t LU_BR_STALL  = 2'd2;
    // Ordinary load-use: one bubble, then MEM->EX forwarding covers it.
    localparam stall_req_t LU_STALL     = 2'd1;
    // ALU result needed by the ID comparator: wait until it sits in MEM.
    localparam stall_req_t ALU_BR_STALL = 2'd1;
    // Load in MEM feeding a branch: wait one more cycle for the load data.
    localparam stall_req_t LD_BR_STALL  = 2'd1;

    // First matching rule wins; ordering matters because a load also
    // writes a register, so the load rules must be checked before the ALU one.
    function automatic stall_req_t hz_req(
        input logic ex_hit,
        input logic ex_mem_read,
        input logic ex_reg_write,
        input logic mem_hit,
        input logic mem_mem_read,
        input logic is_branch
    );
        stall_req_t req;
        req = '0;
        if (ex_mem_read && ex_hit && is_branch)
            req = LU_BR_STALL;
        else if (ex_mem_read && ex_hit)
            req = LU_STALL;
        else if (ex_reg_write && ex_hit && is_branch)
            req = ALU_BR_STALL;
        else if (mem_mem_read && mem_hit && is_branch)
            req = LD_BR_STALL;
        return req;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_match.sv
// ---------------------------------------------------------------------------
// hazard_match
//   Reports whether a producer destination register is read by the
//   instruction currently in ID.
//   Ports:
//     x       in  AW  producer destination register
//     rs, rt  in  AW  ID source registers
//     use_rs  in  1   ID instruction actually reads rs
//     use_rt  in  1   ID instruction actually reads rt
//     hit     out 1   dependency exists
// ---------------------------------------------------------------------------
module hazard_match #(
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          use_rs,
    input  logic          use_rt,
    output logic          hit
);
    import hazard_stall_ctrl_pkg::*;

    logic rs_hit;
    logic rt_hit;
    logic zero_x;

    assign rs_hit = use_rs && (x == rs);
    assign rt_hit = use_rt && (x == rt);
    // $zero is hard-wired, so a "write" to it never produces a value to wait for.
    assign zero_x = ZERO_REG && (x == '0);
    assign hit    = (rs_hit || rt_hit) && !zero_x;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Decode-stage hazard controller for a 5-stage MIPS pipe that resolves
//   branches in ID. Detects load-use, ALU->branch and load->branch hazards,
//   inserts the required number of bubbles, holds the whole pipe while the
//   data memory is busy and flushes IF/ID on taken branches.
//   All enables are combinational from the current inputs and registered
//   state, so they apply in the same cycle as the hazard appears.
//   Ports:
//     clk, rst_n             clock / async active-low reset
//     id_rs, id_rt           ID source registers
//     id_use_rs, id_use_rt   ID instruction reads rs / rt
//     id_is_branch           beq/bne in ID
//     id_br_taken            ID comparator result (meaningful when not stalled)
//     ex_rd, ex_reg_write,
//     ex_mem_read            EX producer info
//     mem_rd, mem_mem_read   MEM producer info
//     mem_busy               data memory not done
//     pc_we, ifid_we         PC / IF-ID write enables
//     idex_bubble            zero the ID/EX control fields
//     ifid_flush             squash IF/ID (taken branch)
//     pipe_freeze            hold every pipeline register
//     stall_o                ID stalled this cycle
//     stall_cycles           saturating count of stall + freeze cycles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int AW       = 5,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_br_taken,
    input  logic [AW-1:0]     ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [AW-1:0]     mem_rd,
    input  logic              mem_mem_read,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              pipe_freeze,
    output logic              stall_o,
    output logic [PERF_W-1:0] stall_cycles
);

    // -----------------------------------------------------------------------
    // Dependency detection
    // -----------------------------------------------------------------------
    logic       ex_hit;
    logic       mem_hit;
    stall_req_t req;

    hazard_match #(.AW(AW), .ZERO_REG(ZERO_REG)) u_ex_match (
        .x      (ex_rd),
        .rs     (id_rs),
        .rt     (id_rt),
        .use_rs (id_use_rs),
        .use_rt (id_use_rt),
        .hit    (ex_hit)
    );

    hazard_match #(.AW(AW), .ZERO_REG(ZERO_REG)) u_mem_match (
        .x      (mem_rd),
        .rs     (id_rs),
        .rt     (id_rt),
        .use_rs (id_use_rs),
        .use_rt (id_use_rt),
        .hit    (mem_hit)
    );

    assign req = hz_req(ex_hit, ex_mem_read, ex_reg_write,
                        mem_hit, mem_mem_read, id_is_branch);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    hz_state_e          state_q, state_d;
    hz_state_e          saved_q, saved_d;   // state to resume after a freeze
    logic [CNT_W-1:0]   cnt_q,   cnt_d;     // stall cycles still owed after this one
    logic [PERF_W-1:0]  perf_q,  perf_d;
    hz_state_e          eff_state;
    logic [CNT_W-1:0]   req_w;
    logic [CNT_W-1:0]   req_m1;

    assign req_w  = CNT_W'(req);
    assign req_m1 = req_w - CNT_W'(1);

    // While frozen, the pipe behaves like the interrupted state as soon as
    // mem_busy drops; this makes the release cycle a normal working cycle
    // rather than one extra dead cycle.
    assign eff_state = (state_q == ST_FREEZE) ? saved_q : state_q;

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        stall_o     = 1'b0;

        if (mem_busy) begin
            // Freeze has priority over any hazard; a hazard arriving now is
            // simply re-evaluated once the memory releases the pipe.
            pipe_freeze = 1'b1;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            state_d     = ST_FREEZE;
            if (state_q != ST_FREEZE)
                saved_d = state_q;
        end else begin
            case (eff_state)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                    if (req != '0) begin
                        stall_o     = 1'b1;
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        cnt_d       = req_m1;
                        state_d     = (req_m1 != '0) ? ST_STALL : ST_IDLE;
                    end
                end
                ST_STALL: begin
                    // Hazards are not re-checked here: the count loaded on
                    // entry already covers the remaining distance.
                    stall_o     = 1'b1;
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                    state_d     = (cnt_q == CNT_W'(1)) ? ST_IDLE : ST_STALL;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The comparator result is stale while ID is held, so only a live
    // branch may squash the fetched instruction.
    assign ifid_flush = id_is_branch && id_br_taken && !stall_o && !pipe_freeze;

    always_comb begin
        perf_d = perf_q;
        if ((stall_o || pipe_freeze) && (perf_q != {PERF_W{1'b1}}))
            perf_d = perf_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            saved_q <= ST_IDLE;
            cnt_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    assign stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_use_rs, id_use_rt, id_is_branch, id_br_taken;
    logic        ex_reg_write, ex_mem_read, mem_mem_read, mem_busy;
    logic        pc_we, ifid_we, idex_bubble, ifid_flush, pipe_freeze, stall_o;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.AW(5), .CNT_W(2), .PERF_W(16), .ZERO_REG(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_br_taken  (id_br_taken),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_mem_read (mem_mem_read),
        .mem_busy     (mem_busy),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .pipe_freeze  (pipe_freeze),
        .stall_o      (stall_o),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output vector order: {pc_we, ifid_we, idex_bubble, ifid_flush, pipe_freeze, stall_o}
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b001001;
    localparam logic [5:0] O_FRZ   = 6'b000010;
    localparam logic [5:0] O_FLUSH = 6'b110100;

    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, pc_we, ifid_we, idex_bubble, ifid_flush, pipe_freeze, stall_o},
            {26'd0, exp});
    endtask

    task automatic clr();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_is_branch = 1'b0; id_br_taken = 1'b0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd0; mem_mem_read = 1'b0; mem_busy = 1'b0;
    endtask

    // Advance one cycle; inputs then change at posedge+1 and checks run at posedge+2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        #3;
        chk_out("reset_out", O_RUN);
        chk("reset_perf", {16'd0, stall_cycles}, 32'd0);
        #9 rst_n = 1'b1;
        step();

        // 1: lw $2 in EX, add reads $2 -> one stall cycle
        clr(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd2; id_rs = 5'd2; id_use_rs = 1;
        #1 chk_out("t1_stall", O_STALL);
        step(); clr();
        #1 chk_out("t1_release", O_RUN);
        chk("t1_perf", {16'd0, stall_cycles}, 32'd1);

        // 2: lw $3 in EX, beq reads $3 -> two stall cycles
        step(); clr(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd3;
        id_rt = 5'd3; id_use_rt = 1; id_is_branch = 1;
        #1 chk_out("t2_stall0", O_STALL);
        // the load has moved to MEM; the count, not a fresh check, keeps the stall
        step(); clr(); mem_mem_read = 1; mem_rd = 5'd3; id_rt = 5'd3; id_use_rt = 1; id_is_branch = 1;
        #1 chk_out("t2_stall1", O_STALL);
        step(); clr();
        #1 chk_out("t2_release", O_RUN);
        chk("t2_perf", {16'd0, stall_cycles}, 32'd3);

        // 3: add $4 in EX, bne reads $4 -> one stall, then taken -> flush one cycle
        clr(); ex_reg_write = 1; ex_rd = 5'd4; id_rs = 5'd5; id_rt = 5'd4;
        id_use_rs = 1; id_use_rt = 1; id_is_branch = 1; id_br_taken = 1;
        #1 chk_out("t3_stall_noflush", O_STALL);
        step(); clr(); mem_rd = 5'd4; id_rs = 5'd5; id_rt = 5'd4;
        id_use_rs = 1; id_use_rt = 1; id_is_branch = 1; id_br_taken = 1;
        #1 chk_out("t3_flush", O_FLUSH);
        step(); clr();
        #1 chk_out("t3_flush_gone", O_RUN);
        chk("t3_perf", {16'd0, stall_cycles}, 32'd4);

        // 4: not-taken branch without hazard; load to $0 never stalls; load in MEM feeding branch
        clr(); id_is_branch = 1; id_rs = 5'd6; id_rt = 5'd7; id_use_rs = 1; id_use_rt = 1;
        ex_reg_write = 1; ex_rd = 5'd8;
        #1 chk_out("t4_not_taken", O_RUN);
        step(); clr(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1;
        #1 chk_out("t4_zero_reg", O_RUN);
        step(); clr(); mem_mem_read = 1; mem_rd = 5'd9; id_rs = 5'd9; id_use_rs = 1; id_is_branch = 1;
        #1 chk_out("t4_ld_br_stall", O_STALL);
        step(); clr();
        #1 chk_out("t4_release", O_RUN);
        chk("t4_perf", {16'd0, stall_cycles}, 32'd5);

        // 5: rule-1 stall, then memory busy three cycles, then the owed stall
        clr(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd10; id_rs = 5'd10; id_use_rs = 1; id_is_branch = 1;
        #1 chk_out("t5_stall0", O_STALL);
        for (int i = 0; i < 3; i++) begin
            step(); clr(); mem_busy = 1; mem_mem_read = 1; mem_rd = 5'd10;
            id_rs = 5'd10; id_use_rs = 1; id_is_branch = 1; id_br_taken = 1;
            #1 chk_out($sformatf("t5_freeze%0d", i), O_FRZ);
        end
        step(); clr();
        #1 chk_out("t5_stall1", O_STALL);
        step(); clr();
        #1 chk_out("t5_release", O_RUN);
        chk("t5_perf", {16'd0, stall_cycles}, 32'd10);

        // busy in the same cycle as a new hazard: freeze first, hazard seen on exit
        clr(); mem_busy = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd11; id_rt = 5'd11; id_use_rt = 1;
        #1 chk_out("t5_busy_hz_freeze", O_FRZ);
        step(); mem_busy = 0;
        #1 chk_out("t5_busy_hz_stall", O_STALL);
        step(); clr();
        #1 chk_out("t5_busy_hz_release", O_RUN);
        chk("t5_busy_perf", {16'd0, stall_cycles}, 32'd12);

        // 6: async reset in the middle of a two-cycle stall
        clr(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd12; id_rs = 5'd12; id_use_rs = 1; id_is_branch = 1;
        #1 chk_out("t6_stall0", O_STALL);
        step(); clr();
        #1 chk_out("t6_stall1", O_STALL);
        #1 rst_n = 1'b0;
        #1 chk_out("t6_reset_out", O_RUN);
        chk("t6_reset_perf", {16'd0, stall_cycles}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        #1 chk_out("t6_after_reset", O_RUN);
        chk("t6_after_perf", {16'd0, stall_cycles}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
